// File: rtl/gcn_result_monitor.sv
// Purpose : self-checking monitor on the GCN result port; header word, then ROWS x NCOL words checked against an external gold ROM.
// Latency : compare retires 1 cycle after a word is accepted, o_mismatch pulses the cycle after; o_done rises 1 cycle after run end.
// Backpres: none, never stalls the GCN; back-to-back words are checked fully pipelined.
// Option  : define GCN_MON_TOL_EN for a signed compare with absolute tolerance TOL (default build is exact equality).
// Ports   : clk, rst (async, active-high); i_rdy/i_result/i_data = GCN result port; o_gold_addr/i_gold_data = sync gold ROM;
//           o_mismatch/o_mis_row/o_mis_col = per-compare report; o_err_cnt/o_chk_cnt = tallies;
//           o_done/o_pass/o_hdr_err/o_short/o_over/o_timeout = run status, held until the next i_rdy rise.
module gcn_result_monitor #(
   parameter int DATA_W    = 16,
   parameter int ROWS      = 100,
   parameter int NCOL      = 2,
   parameter int COL_IDX_W = 8,
   parameter int GOLD_COLS = 8,
   parameter int ADDR_W    = 10,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 80000,
   parameter int TOL       = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rdy,
   input  logic                 i_result,
   input  logic [DATA_W-1:0]    i_data,
   output logic [ADDR_W-1:0]    o_gold_addr,
   input  logic [DATA_W-1:0]    i_gold_data,
   output logic                 o_mismatch,
   output logic [7:0]           o_mis_row,
   output logic [COL_IDX_W-1:0] o_mis_col,
   output logic [CNT_W-1:0]     o_err_cnt,
   output logic [CNT_W-1:0]     o_chk_cnt,
   output logic                 o_done,
   output logic                 o_pass,
   output logic                 o_hdr_err,
   output logic                 o_short,
   output logic                 o_over,
   output logic                 o_timeout
);

   localparam int TOTAL = ROWS * NCOL;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SEL_W = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int ACC_W = $clog2(TOTAL + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int HDR_W = NCOL * COL_IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_CHECK, S_DONE} state_t;
   state_t state, state_nxt;

   logic                 rdy_q;
   logic                 accept, rise, arm, active, tmo_hit, hdr_bad, match;
   logic [HDR_W-1:0]     hdr_q;
   logic [COL_IDX_W-1:0] hdr_col [NCOL];
   logic [ROW_W-1:0]     row;
   logic [SEL_W-1:0]     col_sel;
   logic [ACC_W-1:0]     acc_cnt;
   logic [TMO_W-1:0]     tmo_cnt;
   // Compare stage: the accepted word waits here one cycle for the sync ROM.
   logic                 cmp_vld;
   logic [DATA_W-1:0]    cmp_dat;
   logic [ROW_W-1:0]     cmp_row;
   logic [COL_IDX_W-1:0] cmp_col;

   assign accept  = i_rdy & ~i_result;
   assign rise    = i_rdy & ~rdy_q;
   assign arm     = rise & ((state == S_IDLE) | (state == S_DONE));
   assign active  = (state == S_HDR) | (state == S_CHECK);
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

   for (genvar g = 0; g < NCOL; g++) begin : g_col
      assign hdr_col[g] = hdr_q[g*COL_IDX_W +: COL_IDX_W];
   end

   always_comb begin
      hdr_bad = 1'b0;
      for (int i = 0; i < NCOL; i++)
         if (int'(i_data[i*COL_IDX_W +: COL_IDX_W]) >= GOLD_COLS) hdr_bad = 1'b1;
   end

   // Address of the word expected next; the ROM samples it on the accept edge.
   assign o_gold_addr = ADDR_W'(ADDR_W'(row) * ADDR_W'(GOLD_COLS) + ADDR_W'(hdr_col[col_sel]));

`ifdef GCN_MON_TOL_EN
   logic signed [DATA_W:0] diff;
   logic        [DATA_W:0] adiff;
   always_comb begin
      diff  = $signed({cmp_dat[DATA_W-1], cmp_dat}) - $signed({i_gold_data[DATA_W-1], i_gold_data});
      adiff = $unsigned(diff[DATA_W] ? -diff : diff);
   end
   assign match = (adiff <= (DATA_W+1)'(TOL));
`else
   assign match = (cmp_dat == i_gold_data);
   // TOL only matters for the tolerant compare.
   logic unused_tol;
   assign unused_tol = (TOL != 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rise) state_nxt = S_HDR;
         S_HDR: begin
            if (!i_rdy || tmo_hit)       state_nxt = S_DONE;
            else if (accept && hdr_bad)  state_nxt = S_DONE;
            else if (accept)             state_nxt = S_CHECK;
         end
         // The in-flight compare retires on the same edge that enters DONE.
         S_CHECK: if (!i_rdy || tmo_hit) state_nxt = S_DONE;
         S_DONE:  if (rise) state_nxt = S_HDR;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q <= 1'b0;   hdr_q <= '0;    row <= '0;       col_sel <= '0;
         acc_cnt <= '0;   tmo_cnt <= '0;  cmp_vld <= 1'b0; cmp_dat <= '0;
         cmp_row <= '0;   cmp_col <= '0;  o_mismatch <= 1'b0;
         o_mis_row <= '0; o_mis_col <= '0; o_err_cnt <= '0; o_chk_cnt <= '0;
         o_hdr_err <= 1'b0; o_short <= 1'b0; o_over <= 1'b0; o_timeout <= 1'b0;
      end else begin
         rdy_q      <= i_rdy;
         o_mismatch <= 1'b0;
         cmp_vld    <= 1'b0;
         if (cmp_vld) begin
            if (o_chk_cnt != '1) o_chk_cnt <= o_chk_cnt + 1'b1;
            if (!match) begin
               if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
               o_mismatch <= 1'b1;
               o_mis_row  <= 8'(cmp_row);
               o_mis_col  <= cmp_col;
            end
         end
         if (arm) begin
            hdr_q <= '0;     row <= '0;       col_sel <= '0;   acc_cnt <= '0;  tmo_cnt <= '0;
            o_err_cnt <= '0; o_chk_cnt <= '0; o_mis_row <= '0; o_mis_col <= '0;
            o_hdr_err <= 1'b0; o_short <= 1'b0; o_over <= 1'b0; o_timeout <= 1'b0;
         end else if (active) begin
            if (!i_rdy) begin
               o_short <= (acc_cnt != ACC_W'(TOTAL));
            end else if (tmo_hit) begin
               o_timeout <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (accept && state == S_HDR) begin
                  hdr_q     <= i_data[HDR_W-1:0];
                  o_hdr_err <= hdr_bad;
               end else if (accept) begin
                  if (acc_cnt == ACC_W'(TOTAL)) begin
                     o_over <= 1'b1;
                  end else begin
                     cmp_vld <= 1'b1;
                     cmp_dat <= i_data;
                     cmp_row <= row;
                     cmp_col <= hdr_col[col_sel];
                     acc_cnt <= acc_cnt + 1'b1;
                     if (row == ROW_W'(ROWS - 1)) begin
                        row     <= '0;
                        col_sel <= (col_sel == SEL_W'(NCOL - 1)) ? '0 : col_sel + 1'b1;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   assign o_done = (state == S_DONE);
   assign o_pass = o_done & ~o_hdr_err & ~o_short & ~o_over & ~o_timeout &
                   (o_err_cnt == '0) & (o_chk_cnt == CNT_W'(TOTAL));

endmodule

// File: tb/tb_gcn_result_monitor.sv
module tb_gcn_result_monitor;
   localparam int DATA_W = 16, ROWS = 4, NCOL = 2, COL_IDX_W = 8, GOLD_COLS = 8;
   localparam int ADDR_W = 10, CNT_W = 16, TIMEOUT = 50, TOL = 3;
   localparam int TOTAL = ROWS * NCOL;

   logic              clk = 1'b0;
   logic              rst, i_rdy, i_result;
   logic [15:0]       i_data, i_gold_data;
   logic [ADDR_W-1:0] o_gold_addr;
   logic              o_mismatch, o_done, o_pass, o_hdr_err, o_short, o_over, o_timeout;
   logic [7:0]        o_mis_row, o_mis_col;
   logic [CNT_W-1:0]  o_err_cnt, o_chk_cnt;

   gcn_result_monitor #(
      .DATA_W(DATA_W), .ROWS(ROWS), .NCOL(NCOL), .COL_IDX_W(COL_IDX_W), .GOLD_COLS(GOLD_COLS),
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)
   ) dut (
      .clk(clk), .rst(rst), .i_rdy(i_rdy), .i_result(i_result), .i_data(i_data),
      .o_gold_addr(o_gold_addr), .i_gold_data(i_gold_data), .o_mismatch(o_mismatch),
      .o_mis_row(o_mis_row), .o_mis_col(o_mis_col), .o_err_cnt(o_err_cnt), .o_chk_cnt(o_chk_cnt),
      .o_done(o_done), .o_pass(o_pass), .o_hdr_err(o_hdr_err), .o_short(o_short),
      .o_over(o_over), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   // Gold ROM with one cycle of read latency.
   logic [15:0] gold [ROWS*GOLD_COLS];
   always @(posedge clk) i_gold_data <= gold[o_gold_addr[4:0]];

   int pulse_cnt = 0;
   always @(negedge clk) if (o_mismatch) pulse_cnt <= pulse_cnt + 1;

   int total = 0, pass_cnt = 0, fail_cnt = 0;
   logic [15:0] wq[$];
   int  e_chk, e_err, e_row, e_col;
   bit  e_bad, e_short, e_over, e_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit word_ok(input logic [15:0] d, input logic [15:0] g);
`ifdef GCN_MON_TOL_EN
      int diff;
      diff = int'($signed(d)) - int'($signed(g));
      return ((diff < 0) ? -diff : diff) <= TOL;
`else
      return d == g;
`endif
   endfunction

   // Word k of a run is column hdr[k/ROWS], row k%ROWS.
   function automatic logic [15:0] gold_of(input logic [15:0] hdr, input int k);
      int col;
      col = int'(hdr[(k/ROWS)*8 +: 8]);
      return gold[(k % ROWS) * GOLD_COLS + col];
   endfunction

   task automatic build_wq(input logic [15:0] hdr, input int n);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(k < TOTAL ? gold_of(hdr, k) : 16'($urandom));
   endtask

   task automatic predict(input logic [15:0] hdr);
      int n;
      n = wq.size();
      e_bad = (hdr[7:0] >= 8'(GOLD_COLS)) || (hdr[15:8] >= 8'(GOLD_COLS));
      e_err = 0; e_row = 0; e_col = 0; e_chk = 0; e_short = 0; e_over = 0;
      if (!e_bad) begin
         e_chk = (n < TOTAL) ? n : TOTAL;
         for (int k = 0; k < e_chk; k++)
            if (!word_ok(wq[k], gold_of(hdr, k))) begin
               e_err++;
               e_row = k % ROWS;
               e_col = int'(hdr[(k/ROWS)*8 +: 8]);
            end
         e_short = (n < TOTAL);
         e_over  = (n > TOTAL);
      end
      e_pass = !e_bad && !e_short && !e_over && e_err == 0 && e_chk == TOTAL;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      while (!o_done && n < limit) begin tick(); n++; end
      chk({tag, ".done"}, 32'(o_done), 1);
      tick();
   endtask

   // Arm, header, words with random idle gaps, then drop i_rdy with a valid word on the falling cycle.
   task automatic send_run(input string tag, input logic [15:0] hdr);
      i_rdy = 1'b0; i_result = 1'b1; i_data = 16'($urandom);
      repeat (2) tick();
      i_rdy = 1'b1; tick();
      i_result = 1'b0; i_data = hdr; tick();
      foreach (wq[k]) begin
         repeat ($urandom_range(0, 2)) begin i_result = 1'b1; i_data = 16'($urandom); tick(); end
         i_result = 1'b0; i_data = wq[k]; tick();
      end
      i_rdy = 1'b0; i_result = 1'b0; i_data = 16'($urandom); tick();
      i_result = 1'b1;
      wait_done(tag, 20);
   endtask

   task automatic run(input string tag, input logic [15:0] hdr);
      int base;
      predict(hdr);
      base = pulse_cnt;
      send_run(tag, hdr);
      chk({tag, ".chk_cnt"}, 32'(o_chk_cnt), e_chk);
      chk({tag, ".err_cnt"}, 32'(o_err_cnt), e_err);
      chk({tag, ".pulses"},  pulse_cnt - base, e_err);
      chk({tag, ".flags"}, {26'd0, o_pass, o_hdr_err, o_short, o_over, o_timeout, o_done},
          {26'd0, e_pass, e_bad, e_short, e_over, 1'b0, 1'b1});
      if (e_err > 0) begin
         chk({tag, ".mis_row"}, 32'(o_mis_row), e_row);
         chk({tag, ".mis_col"}, 32'(o_mis_col), e_col);
      end
   endtask

   initial begin
      logic [15:0] hdr;
      int r;
      foreach (gold[a]) gold[a] = 16'($urandom);
      rst = 1'b1; i_rdy = 1'b0; i_result = 1'b1; i_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.addr", 32'(o_gold_addr), 0);
      chk("reset.cnts", {o_err_cnt, o_chk_cnt}, 0);
      chk("reset.status", {23'd0, o_mismatch, o_mis_row, o_done, o_pass, o_hdr_err, o_short,
          o_over, o_timeout} | 32'(o_mis_col), 0);
      rst = 1'b0; tick();

      // Clean run, then the same run with word 6 (col 5, row 1) off by +3.
      build_wq(16'h0503, TOTAL);
      run("A", 16'h0503);
      chk("A.spec_pass", 32'(o_pass), 1);
      wq[5] = wq[5] + 16'd3;
      run("B", 16'h0503);
`ifdef GCN_MON_TOL_EN
      chk("B.spec_err", 32'(o_err_cnt), 0);
`else
      chk("B.spec_err", 32'(o_err_cnt), 1);
      chk("B.spec_row_col", {o_mis_row, o_mis_col}, 16'h0105);
`endif

      // Random headers with random corruption.
      for (int it = 0; it < 5; it++) begin
         hdr = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
         build_wq(hdr, TOTAL);
         foreach (wq[k]) begin
            r = $urandom_range(0, 9);
            if (r < 2)       wq[k] = wq[k] + 16'($urandom_range(1, 5));
            else if (r == 2) wq[k] = 16'($urandom);
         end
         run("RND", hdr);
      end

      // Header index out of range.
      wq.delete();
      run("HDR", 16'h0009);
      chk("HDR.spec_err", {30'd0, o_hdr_err, o_done}, 3);

      // Short and over-long runs.
      build_wq(16'h0106, 5);
      run("SHORT", 16'h0106);
      chk("SHORT.spec_chk", 32'(o_chk_cnt), 5);
      build_wq(16'h0702, 10);
      run("OVER", 16'h0702);
      chk("OVER.spec", {15'd0, o_over, o_chk_cnt}, {15'd0, 1'b1, 16'd8});

      // Timeout: i_rdy high, no words.
      i_rdy = 1'b0; i_result = 1'b1; repeat (2) tick();
      i_rdy = 1'b1; tick();
      repeat (40) tick();
      chk("TMO.early", 32'(o_done), 0);
      wait_done("TMO", 30);
      chk("TMO.flags", {29'd0, o_timeout, o_pass, o_short}, 4);
      chk("TMO.chk_cnt", 32'(o_chk_cnt), 0);
      i_rdy = 1'b0; tick();
      i_rdy = 1'b1; tick();
      chk("TMO.rearm", {26'd0, o_done, o_pass, o_timeout, o_short, o_over, o_hdr_err}, 0);

      // Reset in the middle of a run, then a clean run.
      i_rdy = 1'b0; tick();
      i_rdy = 1'b1; tick();
      i_result = 1'b0; i_data = 16'h0503; tick();
      for (int k = 0; k < 3; k++) begin i_data = gold_of(16'h0503, k); tick(); end
      i_result = 1'b1;
      chk("RST.addr_pre", 32'(o_gold_addr), 3 * GOLD_COLS + 3);
      chk("RST.chk_pre", 32'(o_chk_cnt), 2);
      #2 rst = 1'b1;
      #1;
      chk("RST.addr", 32'(o_gold_addr), 0);
      chk("RST.cnts", {o_err_cnt, o_chk_cnt}, 0);
      chk("RST.status", {23'd0, o_mismatch, o_mis_row, o_done, o_pass, o_hdr_err, o_short,
          o_over, o_timeout} | 32'(o_mis_col), 0);
      i_rdy = 1'b0;
      #3 rst = 1'b0;
      tick();
      build_wq(16'h0503, TOTAL);
      run("POST", 16'h0503);
      chk("POST.spec_pass", 32'(o_pass), 1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
